// File: rtl/nfc_ci_page_sequencer.sv
// Host page-request sequencer: expands READ/PROGRAM/ERASE/RESET into CAL and DATA atoms for
// the ACG CI port, waits out tWB, polls ready/busy with a timeout and returns a completion.
module nfc_ci_page_sequencer #(
  parameter int unsigned NumberOfWays    = 2,
  parameter int unsigned PageBeats       = 2048,
  parameter int unsigned RBSettleCycles  = 16,
  parameter int unsigned RBTimeoutCycles = 1048576
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic                    iReqValid,
  output logic                    oReqReady,
  input  logic [1:0]              iReqOpcode,
  input  logic [NumberOfWays-1:0] iReqWay,
  input  logic [23:0]             iReqRowAddr,
  input  logic [15:0]             iReqColAddr,
  output logic                    oRspValid,
  input  logic                    iRspReady,
  output logic                    oRspTimeout,
  output logic [7:0]              oCI_ACG_Command,
  output logic [2:0]              oCI_ACG_CommandOption,
  input  logic                    iACG_CI_Ready,
  input  logic                    iACG_CI_LastStep,
  output logic [NumberOfWays-1:0] oCI_ACG_TargetWay,
  output logic [15:0]             oCI_ACG_NumOfData,
  output logic                    oCI_ACG_CASelect,
  output logic [7:0]              oCI_ACG_CAData,
  input  logic [NumberOfWays-1:0] iACG_CI_ReadyBusy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CAL_ISSUE = 3'd1;
  localparam logic [2:0] S_CAL_WAIT  = 3'd2;
  localparam logic [2:0] S_DAT_ISSUE = 3'd3;
  localparam logic [2:0] S_DAT_WAIT  = 3'd4;
  localparam logic [2:0] S_SETTLE    = 3'd5;
  localparam logic [2:0] S_POLL      = 3'd6;
  localparam logic [2:0] S_RESP      = 3'd7;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;

  localparam logic [15:0] DataLen    = 16'(PageBeats - 1);
  localparam logic [15:0] SettleLast = 16'(RBSettleCycles - 1);
  localparam logic [23:0] TmoLast    = 24'(RBTimeoutCycles - 1);

  logic [2:0]              r_state;
  logic [1:0]              r_op;
  logic [NumberOfWays-1:0] r_way;
  logic [23:0]             r_row;
  logic [15:0]             r_col;
  logic                    r_confirm;  // PROGRAM: data phase done, next CAL is the 10h confirm
  logic                    r_last;
  logic                    r_ca_active;
  logic [2:0]              r_ca_idx;
  logic [15:0]             r_settle_cnt;
  logic [23:0]             r_tmo_cnt;
  logic                    r_timeout;

  logic [2:0] w_cal_len;
  logic [7:0] w_ca_byte;
  logic       w_ca_sel;
  logic       w_rb_ok;

  assign w_rb_ok = (iACG_CI_ReadyBusy & r_way) == r_way;

  always_comb begin
    w_cal_len = 3'd0;
    case (r_op)
      OP_READ:  w_cal_len = 3'd6;
      OP_PROG:  w_cal_len = r_confirm ? 3'd0 : 3'd5;
      OP_ERASE: w_cal_len = 3'd4;
      default:  w_cal_len = 3'd0;
    endcase
  end

  always_comb begin
    {w_ca_sel, w_ca_byte} = 9'h000;
    case (r_op)
      OP_READ, OP_PROG: begin
        case (r_ca_idx)
          3'd0: {w_ca_sel, w_ca_byte} = (r_op == OP_READ) ? 9'h100 :
                                        (r_confirm ? 9'h110 : 9'h180);
          3'd1: w_ca_byte = r_col[7:0];
          3'd2: w_ca_byte = r_col[15:8];
          3'd3: w_ca_byte = r_row[7:0];
          3'd4: w_ca_byte = r_row[15:8];
          3'd5: w_ca_byte = r_row[23:16];
          3'd6: {w_ca_sel, w_ca_byte} = 9'h130;
          default: {w_ca_sel, w_ca_byte} = 9'h000;
        endcase
      end
      OP_ERASE: begin
        case (r_ca_idx)
          3'd0: {w_ca_sel, w_ca_byte} = 9'h160;
          3'd1: w_ca_byte = r_row[7:0];
          3'd2: w_ca_byte = r_row[15:8];
          3'd3: w_ca_byte = r_row[23:16];
          3'd4: {w_ca_sel, w_ca_byte} = 9'h1D0;
          default: {w_ca_sel, w_ca_byte} = 9'h000;
        endcase
      end
      default: {w_ca_sel, w_ca_byte} = 9'h1FF;
    endcase
  end

  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      r_state      <= S_IDLE;
      r_op         <= 2'd0;
      r_way        <= '0;
      r_row        <= 24'd0;
      r_col        <= 16'd0;
      r_confirm    <= 1'b0;
      r_last       <= 1'b0;
      r_ca_active  <= 1'b0;
      r_ca_idx     <= 3'd0;
      r_settle_cnt <= 16'd0;
      r_tmo_cnt    <= 24'd0;
      r_timeout    <= 1'b0;
    end else begin
      if (r_ca_active) begin
        if (r_ca_idx == w_cal_len) r_ca_active <= 1'b0;
        else                       r_ca_idx    <= r_ca_idx + 3'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (iReqValid) begin
            r_op      <= iReqOpcode;
            r_way     <= iReqWay;
            r_row     <= iReqRowAddr;
            r_col     <= iReqColAddr;
            r_confirm <= 1'b0;
            r_timeout <= 1'b0;
            r_state   <= S_CAL_ISSUE;
          end
        end
        S_CAL_ISSUE: begin
          if (iACG_CI_Ready) begin
            r_ca_active <= 1'b1;
            r_ca_idx    <= 3'd0;
            r_last      <= iACG_CI_LastStep;
            r_state     <= S_CAL_WAIT;
          end
        end
        S_CAL_WAIT: begin
          if (iACG_CI_LastStep) r_last <= 1'b1;
          if (!r_ca_active && r_last) begin
            r_last <= 1'b0;
            if (r_op == OP_PROG && !r_confirm) begin
              r_state <= S_DAT_ISSUE;
            end else begin
              r_settle_cnt <= 16'd0;
              r_tmo_cnt    <= 24'd0;
              r_state      <= S_SETTLE;
            end
          end
        end
        S_DAT_ISSUE: begin
          if (iACG_CI_Ready) begin
            r_last  <= iACG_CI_LastStep;
            r_state <= S_DAT_WAIT;
          end
        end
        S_DAT_WAIT: begin
          if (iACG_CI_LastStep) r_last <= 1'b1;
          if (r_last) begin
            r_last <= 1'b0;
            if (r_op == OP_READ) begin
              r_state <= S_RESP;
            end else begin
              r_confirm <= 1'b1;
              r_state   <= S_CAL_ISSUE;
            end
          end
        end
        S_SETTLE: begin
          r_tmo_cnt <= r_tmo_cnt + 24'd1;
          if (r_settle_cnt >= SettleLast) r_state <= S_POLL;
          else r_settle_cnt <= r_settle_cnt + 16'd1;
        end
        S_POLL: begin
          r_tmo_cnt <= r_tmo_cnt + 24'd1;
          if (w_rb_ok) begin
            r_state <= (r_op == OP_READ) ? S_DAT_ISSUE : S_RESP;
          end else if (r_tmo_cnt >= TmoLast) begin
            r_timeout <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        default: begin
          if (iRspReady) begin
            r_timeout <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign oReqReady             = (r_state == S_IDLE);
  assign oRspValid             = (r_state == S_RESP);
  assign oRspTimeout           = (r_state == S_RESP) && r_timeout;
  assign oCI_ACG_CommandOption = 3'd0;
  assign oCI_ACG_TargetWay     = r_way;
  assign oCI_ACG_CASelect      = (r_state == S_CAL_WAIT) && r_ca_active && w_ca_sel;
  assign oCI_ACG_CAData        = ((r_state == S_CAL_WAIT) && r_ca_active) ? w_ca_byte : 8'h00;

  always_comb begin
    oCI_ACG_Command   = 8'h00;
    oCI_ACG_NumOfData = 16'd0;
    if (r_state == S_CAL_ISSUE) begin
      oCI_ACG_Command   = 8'h01;
      oCI_ACG_NumOfData = {13'd0, w_cal_len};
    end else if (r_state == S_DAT_ISSUE) begin
      oCI_ACG_Command   = (r_op == OP_READ) ? 8'h04 : 8'h02;
      oCI_ACG_NumOfData = DataLen;
    end
  end

endmodule

// File: tb/tb_nfc_ci_page_sequencer.sv
// Directed bench for nfc_ci_page_sequencer; a second instance with a short timeout covers the
// ready/busy abort path.
module tb_nfc_ci_page_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, rsp_ready, acg_ready, acg_last;
  logic [1:0]  req_op, req_way, rb;
  logic [23:0] req_row;
  logic [15:0] req_col;

  logic        req_ready, rsp_valid, rsp_tmo, ca_sel;
  logic [7:0]  cmd, ca_data;
  logic [2:0]  cmd_opt;
  logic [1:0]  tway;
  logic [15:0] nod;

  logic        t_req_ready, t_rsp_valid, t_rsp_tmo, t_ca_sel;
  logic [7:0]  t_cmd, t_ca_data;
  logic [2:0]  t_cmd_opt;
  logic [1:0]  t_tway;
  logic [15:0] t_nod;

  nfc_ci_page_sequencer dut (
    .iSystemClock(clk), .iReset(rst_n), .iReqValid(req_valid), .oReqReady(req_ready),
    .iReqOpcode(req_op), .iReqWay(req_way), .iReqRowAddr(req_row), .iReqColAddr(req_col),
    .oRspValid(rsp_valid), .iRspReady(rsp_ready), .oRspTimeout(rsp_tmo),
    .oCI_ACG_Command(cmd), .oCI_ACG_CommandOption(cmd_opt), .iACG_CI_Ready(acg_ready),
    .iACG_CI_LastStep(acg_last), .oCI_ACG_TargetWay(tway), .oCI_ACG_NumOfData(nod),
    .oCI_ACG_CASelect(ca_sel), .oCI_ACG_CAData(ca_data), .iACG_CI_ReadyBusy(rb)
  );

  nfc_ci_page_sequencer #(.RBTimeoutCycles(64)) dut_t (
    .iSystemClock(clk), .iReset(rst_n), .iReqValid(req_valid), .oReqReady(t_req_ready),
    .iReqOpcode(req_op), .iReqWay(req_way), .iReqRowAddr(req_row), .iReqColAddr(req_col),
    .oRspValid(t_rsp_valid), .iRspReady(rsp_ready), .oRspTimeout(t_rsp_tmo),
    .oCI_ACG_Command(t_cmd), .oCI_ACG_CommandOption(t_cmd_opt), .iACG_CI_Ready(acg_ready),
    .iACG_CI_LastStep(acg_last), .oCI_ACG_TargetWay(t_tway), .oCI_ACG_NumOfData(t_nod),
    .oCI_ACG_CASelect(t_ca_sel), .oCI_ACG_CAData(t_ca_data), .iACG_CI_ReadyBusy(rb)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {req_valid, rsp_ready, acg_ready, acg_last} = 4'b0;
    {req_op, req_way, rb, req_row, req_col} = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send_req(input logic [1:0] op, input logic [1:0] way, input logic [23:0] row,
                          input logic [15:0] col);
    check_eq("idle_req_ready", {31'd0, req_ready}, 32'd1);
    rb = 2'b00;
    req_valid = 1'b1;
    {req_op, req_way, req_row, req_col} = {op, way, row, col};
    step();
    req_valid = 1'b0;
    check_eq("busy_req_ready", {31'd0, req_ready}, 32'd0);
    check_eq("target_way", {30'd0, tway}, {30'd0, way});
  endtask

  // Present CAL acceptance after rdy_delay cycles, check the CA stream, pulse LastStep at
  // stream index last_at (last_at > n means the first cycle after the stream).
  task automatic expect_cal(input string tag, input int n, input logic [55:0] bytes,
                            input logic [6:0] sel, input int rdy_delay, input int last_at);
    for (int i = 0; i < rdy_delay; i++) begin
      check_eq({tag, "_cmd_hold"}, {24'd0, cmd}, 32'h01);
      check_eq({tag, "_nod_hold"}, {16'd0, nod}, n);
      step();
    end
    check_eq({tag, "_cmd"}, {24'd0, cmd}, 32'h01);
    check_eq({tag, "_nod"}, {16'd0, nod}, n);
    acg_ready = 1'b1;
    step();
    acg_ready = 1'b0;
    check_eq({tag, "_cmd_drop"}, {24'd0, cmd}, 32'h00);
    for (int i = 0; i <= n; i++) begin
      check_eq({tag, "_byte"}, {24'd0, ca_data}, {24'd0, bytes[8*i +: 8]});
      check_eq({tag, "_sel"}, {31'd0, ca_sel}, {31'd0, sel[i]});
      acg_last = (i == last_at);
      step();
      acg_last = 1'b0;
    end
    if (last_at > n) begin
      acg_last = 1'b1;
      step();
      acg_last = 1'b0;
    end
    check_eq({tag, "_post_data"}, {24'd0, ca_data}, 32'h00);
    check_eq({tag, "_post_sel"}, {31'd0, ca_sel}, 32'd0);
    step();
  endtask

  task automatic expect_data(input string tag, input logic [7:0] cexp);
    check_eq({tag, "_cmd"}, {24'd0, cmd}, {24'd0, cexp});
    check_eq({tag, "_nod"}, {16'd0, nod}, 32'd2047);
    acg_ready = 1'b1;
    step();
    acg_ready = 1'b0;
    check_eq({tag, "_cmd_drop"}, {24'd0, cmd}, 32'h00);
    acg_last = 1'b1;
    step();
    acg_last = 1'b0;
    step();
  endtask

  // Counts cycles from SETTLE entry until an atom or a response appears (bounded by limit).
  task automatic poll(input int rb_rise, input logic [1:0] way, input int limit,
                      input bit use_t, output int c);
    c = 0;
    rb = (c >= rb_rise) ? way : 2'b00;
    while (c < limit && !(use_t ? (t_cmd != 0 || t_rsp_valid) : (cmd != 0 || rsp_valid))) begin
      step();
      c++;
      rb = (c >= rb_rise) ? way : 2'b00;
    end
  endtask

  task automatic finish_rsp(input string tag, input int hold);
    check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check_eq({tag, "_rsp_tmo"}, {31'd0, rsp_tmo}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq({tag, "_rsp_hold"}, {31'd0, rsp_valid}, 32'd1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq({tag, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
    check_eq({tag, "_back_idle"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    {req_valid, rsp_ready, acg_ready, acg_last} = 4'b0;
    {req_op, req_way, rb, req_row, req_col} = '0;
    step();
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_cmd", {24'd0, cmd}, 32'd0);
    check_eq("rst_opt", {29'd0, cmd_opt}, 32'd0);
    check_eq("rst_rsp", {30'd0, rsp_valid, rsp_tmo}, 32'd0);
    check_eq("rst_ca", {23'd0, ca_sel, ca_data}, 32'd0);
    check_eq("rst_nod_way", {14'd0, nod, tway}, 32'd0);
    rst_n = 1'b1;
    step();

    // READ with delayed ACG acceptance and LastStep inside the stream
    send_req(2'd0, 2'b01, 24'h012345, 16'h0000);
    expect_cal("rd", 6, {8'h30, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00}, 7'b1000001, 10, 3);
    poll(0, 2'b01, 200, 1'b0, cyc);
    check_eq("rd_settle_lat", cyc, 17);
    check_eq("rd_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
    expect_data("rd_data", 8'h04);
    finish_rsp("rd", 5);

    // PROGRAM with LastStep after the stream and R/B rising late
    send_req(2'd1, 2'b10, 24'h000100, 16'h0010);
    expect_cal("pg", 5, {8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h10, 8'h80}, 7'b0000001, 0, 6);
    check_eq("pg_no_rsp", {31'd0, rsp_valid}, 32'd0);
    expect_data("pg_data", 8'h02);
    expect_cal("pg_conf", 0, {48'h0, 8'h10}, 7'b0000001, 0, 0);
    poll(25, 2'b10, 200, 1'b0, cyc);
    check_eq("pg_rsp_lat", cyc, 26);
    check_eq("pg_no_atom", {24'd0, cmd}, 32'd0);
    finish_rsp("pg", 0);

    // ERASE: R/B low for 100 poll cycles after settle
    send_req(2'd2, 2'b01, 24'h012345, 16'hFFFF);
    expect_cal("er", 4, {16'h0, 8'hD0, 8'h01, 8'h23, 8'h45, 8'h60}, 7'b0010001, 0, 4);
    poll(116, 2'b01, 400, 1'b0, cyc);
    check_eq("er_rsp_lat", cyc, 117);
    check_eq("er_no_atom", {24'd0, cmd}, 32'd0);
    finish_rsp("er", 2);

    // READ timeout on the short-timeout instance; no DATA_IN may follow
    do_reset();
    send_req(2'd0, 2'b10, 24'hABCDEF, 16'h1234);
    expect_cal("to", 6, {8'h30, 8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h00}, 7'b1000001, 0, 0);
    poll(100000, 2'b10, 300, 1'b1, cyc);
    check_eq("to_rsp_lat", cyc, 64);
    check_eq("to_rsp_valid", {31'd0, t_rsp_valid}, 32'd1);
    check_eq("to_rsp_tmo", {31'd0, t_rsp_tmo}, 32'd1);
    check_eq("to_no_data_in", {24'd0, t_cmd}, 32'd0);
    check_eq("to_long_still_polling", {23'd0, rsp_valid, cmd}, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("to_back_idle", {31'd0, t_req_ready}, 32'd1);
    do_reset();

    // Reset in the middle of the CA stream, then a RESET request
    send_req(2'd0, 2'b01, 24'h000000, 16'h00AA);
    acg_ready = 1'b1;
    step();
    acg_ready = 1'b0;
    step();
    check_eq("mid_byte1", {24'd0, ca_data}, 32'hAA);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("mid_rst_ca", {23'd0, ca_sel, ca_data}, 32'd0);
    check_eq("mid_rst_cmd_way", {22'd0, cmd, tway}, 32'd0);
    check_eq("mid_rst_rsp", {30'd0, rsp_valid, rsp_tmo}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("mid_post_cmd", {24'd0, cmd}, 32'd0);
    send_req(2'd3, 2'b01, 24'h000000, 16'h0000);
    expect_cal("rs", 0, {48'h0, 8'hFF}, 7'b0000001, 0, 0);
    poll(0, 2'b01, 200, 1'b0, cyc);
    check_eq("rs_rsp_lat", cyc, 17);
    finish_rsp("rs", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
